// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader that writes verified machine code into instruction RAM
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         imem_wr_en,
    output logic [D-1:0] imem_addr,
    output logic [W-1:0] imem_dat,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_INS_HI,
        S_INS_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    // High-byte bits above the machine-code width must be zero
    localparam logic [7:0]  RSV_MASK = 8'hFF << (W - 8);
    localparam logic [16:0] CAP      = 17'(1) << D;

    state_t       state;
    logic [15:0]  count;
    logic [D:0]   index;
    logic [7:0]   csum;
    logic [W-9:0] hi_bits;

    logic         accept;
    logic [15:0]  cnt_n;
    logic [D:0]   index_inc;
    logic         last_word;

    assign accept    = in_valid && in_ready;
    assign cnt_n     = {count[15:8], in_data};
    assign index_inc = index + 1'b1;
    assign last_word = (17'(index_inc) == {1'b0, count});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            imem_wr_en <= 1'b0;
            imem_addr  <= '0;
            imem_dat   <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            index      <= '0;
            csum       <= '0;
            hi_bits    <= '0;
        end else begin
            imem_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_CNT_HI;
                        in_ready  <= 1'b1;
                        csum      <= '0;
                        index     <= '0;
                        cpu_hold  <= 1'b1;
                        load_done <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        count[15:8] <= in_data;
                        csum        <= csum ^ in_data;
                        state       <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        count[7:0] <= in_data;
                        csum       <= csum ^ in_data;
                        if ({1'b0, cnt_n} > CAP) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else if (cnt_n == 16'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_INS_HI;
                        end
                    end
                end
                S_INS_HI: begin
                    if (accept) begin
                        csum <= csum ^ in_data;
                        if ((in_data & RSV_MASK) != 8'd0) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            hi_bits <= in_data[W-9:0];
                            state   <= S_INS_LO;
                        end
                    end
                end
                S_INS_LO: begin
                    if (accept) begin
                        csum       <= csum ^ in_data;
                        imem_wr_en <= 1'b1;
                        imem_addr  <= index[D-1:0];
                        imem_dat   <= {hi_bits, in_data};
                        index      <= index_inc;
                        state      <= last_word ? S_CHK : S_INS_HI;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with a write scoreboard
module tb_prog_loader;

    localparam int D = 12;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   in_data = 8'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         imem_wr_en;
    logic [D-1:0] imem_addr;
    logic [W-1:0] imem_dat;
    logic         cpu_hold;
    logic         load_done;
    logic         err;

    prog_loader #(.D(D), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_wr_en (imem_wr_en),
        .imem_addr  (imem_addr),
        .imem_dat   (imem_dat),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] dat;
    } wr_t;

    typedef struct packed {
        logic [3:0]  len;
        logic [63:0] bytes;
        logic        done;
        logic        fail;
        logic [1:0]  nwr;
        logic [17:0] wd;
        logic        bp;
    } vec_t;

    wr_t          sb[$];
    int           checks = 0;
    int           errors = 0;
    int           nwrites = 0;
    logic [D-1:0] last_addr = '0;
    logic         prev_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every RAM write must match the next expected one
    always @(negedge clk) begin
        if (reset && imem_wr_en) begin
            nwrites++;
            last_addr = imem_addr;
            chk("wr_single_cycle", 32'(prev_wr), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h dat %0h expected no write", imem_addr, imem_dat);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_dat", 32'(imem_dat), 32'(e.dat));
            end
        end
        prev_wr = imem_wr_en;
    end

    task automatic send_byte(input logic [7:0] b, input logic bp);
        int gap;
        int t;
        gap = bp ? int'($urandom_range(0, 3)) : 0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got in_ready 0 expected 1 within 20 cycles");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_wr(input int a, input logic [W-1:0] d);
        wr_t e;
        e.addr = D'(a);
        e.dat  = d;
        sb.push_back(e);
    endtask

    task automatic check_end(input string tag, input logic done, input logic fail);
        chk({tag, "_load_done"}, 32'(load_done), 32'(done));
        chk({tag, "_err"}, 32'(err), 32'(fail));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!done));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [63:0] bb;
        bb = v.bytes;
        for (int i = 0; i < int'(v.nwr); i++)
            push_wr(i, (i == 0) ? v.wd[17:9] : v.wd[8:0]);
        pulse_start();
        for (int i = 0; i < int'(v.len); i++)
            send_byte(bb[63-8*i -: 8], v.bp);
        @(negedge clk);
        check_end(tag, v.done, v.fail);
    endtask

    vec_t tbl [6];

    initial begin
        logic [63:0] t2;
        logic [7:0]  cs;
        logic [W-1:0] wdat;
        int          base;

        // Frames: N=2 {05A,1A3}; checksum 00^02^00^5A^01^A3 = FA
        tbl[0] = '{len: 4'd7, bytes: 64'h0002005A01A3FA00, done: 1'b1, fail: 1'b0, nwr: 2'd2, wd: {9'h05A, 9'h1A3}, bp: 1'b0};
        tbl[1] = '{len: 4'd7, bytes: 64'h0002005A01A3FB00, done: 1'b0, fail: 1'b1, nwr: 2'd2, wd: {9'h05A, 9'h1A3}, bp: 1'b0};
        tbl[2] = '{len: 4'd3, bytes: 64'h0001020000000000, done: 1'b0, fail: 1'b1, nwr: 2'd0, wd: 18'd0, bp: 1'b0};
        tbl[3] = '{len: 4'd3, bytes: 64'h0000000000000000, done: 1'b1, fail: 1'b0, nwr: 2'd0, wd: 18'd0, bp: 1'b0};
        tbl[4] = '{len: 4'd2, bytes: 64'h1001000000000000, done: 1'b0, fail: 1'b1, nwr: 2'd0, wd: 18'd0, bp: 1'b0};
        tbl[5] = '{len: 4'd7, bytes: 64'h0002005A01A3FA00, done: 1'b1, fail: 1'b0, nwr: 2'd2, wd: {9'h05A, 9'h1A3}, bp: 1'b1};
        t2 = 64'h0002005A01A3FA00;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b1;

        // Bytes offered while idle are not consumed
        @(negedge clk);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        for (int k = 0; k < 6; k++)
            run_vec(tbl[k], $sformatf("vec%0d", k));

        // start pulse in the middle of a frame is ignored
        push_wr(0, 9'h05A);
        push_wr(1, 9'h1A3);
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(t2[63-8*i -: 8], 1'b0);
        pulse_start();
        for (int i = 3; i < 7; i++) send_byte(t2[63-8*i -: 8], 1'b0);
        @(negedge clk);
        check_end("busy_start", 1'b1, 1'b0);

        // Asynchronous reset mid-frame, then a clean reload
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(t2[63-8*i -: 8], 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_wr_en", 32'(imem_wr_en), 32'd0);
        chk("arst_addr", 32'(imem_addr), 32'd0);
        chk("arst_dat", 32'(imem_dat), 32'd0);
        chk("arst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("arst_load_done", 32'(load_done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_vec(tbl[0], "after_reset");

        // Full image N = 2**D, last write at the top address
        base = nwrites;
        cs = 8'h10 ^ 8'h00;
        pulse_start();
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 4096; i++) begin
            wdat = W'(i * 37 + 5);
            push_wr(i, wdat);
            cs = cs ^ {7'd0, wdat[8]} ^ wdat[7:0];
            send_byte({7'd0, wdat[8]}, 1'b0);
            send_byte(wdat[7:0], 1'b0);
        end
        send_byte(cs, 1'b0);
        @(negedge clk);
        check_end("full", 1'b1, 1'b0);
        chk("full_last_addr", 32'(last_addr), 32'hFFF);
        chk("full_nwrites", 32'(nwrites - base), 32'd4096);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
